vip_uart_rx_monitor: RTL
========================

Name: vip_uart_rx_monitor

Overview:
- Simulation-side UART receiver that consumes the DUT `uart_tx` line in the Cheshire SoC testbench VIP.
- Decodes 8N1 frames (optionally 8E1) sampled mid-bit and buffers the received bytes in a FIFO.
- Presents the bytes on a valid/ready stream for console print-out and scoreboard checks.
- Flags framing errors, FIFO overflow and completed text lines.

Parameters:
- BaudDiv, 16, clk cycles per UART bit; legal range ≥ 4.
- FifoDepth, 8, byte FIFO entries; power of two, ≥ 2.
- EolChar, 8'h0A, byte value counted as end-of-line.

Ports:
- clk_i  in  1  testbench clock.
- rst_i  in  1  asynchronous reset, active-high.
- uart_rx_i  in  1  serial line from DUT `uart_tx`; idle level is high.
- byte_o  out  8  head byte of the FIFO.
- byte_valid_o  out  1  FIFO not empty.
- byte_ready_i  in  1  consumer accepts `byte_o`.
- level_o  out  $clog2(FifoDepth)+1  FIFO occupancy.
- frame_err_o  out  1  one-cycle pulse when the stop bit samples 0.
- parity_err_o  out  1  one-cycle pulse on parity mismatch; tied 0 without the optional feature.
- overflow_o  out  1  sticky; set when a byte is dropped because the FIFO is full.
- eol_cnt_o  out  16  count of EolChar bytes pushed into the FIFO; wraps at 16'hFFFF→0.

Behaviour:
- Reset values (asynchronous, `rst_i`=1):
  - all outputs 0 except `byte_o` = 8'h00;
  - synchroniser flops = 1; FSM = IDLE; counters = 0; FIFO empty.
- Input synchroniser: 2-FF stage. All decisions use the synced bit, giving 2 cycles of latency relative to `uart_rx_i`.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP, WAIT_HIGH.
- IDLE: a synced falling edge (previous 1, current 0) → START, with the bit counter loaded to BaudDiv/2 − 1 (floor division).
- START: on counter expiry, sample the line.
  - 1 → false start, back to IDLE.
  - 0 → DATA, with the counter loaded to BaudDiv − 1 and the bit index at 0.
- DATA: sample on each expiry and shift in LSB first. After bit index 7 → STOP (or PARITY). The counter reloads to BaudDiv − 1 on every expiry.
- STOP: sample on expiry.
  - 1 → push byte, then IDLE. A new falling edge is recognised from the next cycle.
  - 0 → pulse `frame_err_o`, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until the synced line is 1, then IDLE. A break condition never generates bytes.
- Push timing: the push happens in the cycle after the stop sample. `byte_valid_o` rises one cycle after that if the FIFO was empty (first-word registered output).
- FIFO rules:
  - pop occurs when `byte_valid_o` && `byte_ready_i`;
  - push is accepted when not full, or when full with a pop in the same cycle;
  - otherwise the byte is dropped and `overflow_o` is set (cleared only by reset);
  - simultaneous push and pop leaves `level_o` unchanged;
  - read/write pointers wrap modulo FifoDepth;
  - `byte_o` is stable while `byte_valid_o` && !`byte_ready_i`.
- `eol_cnt_o` increments on an accepted push of EolChar only. Dropped bytes are not counted.
- Reset mid-frame: the frame is abandoned and nothing is pushed. After release the monitor is in IDLE. If the line is low at release, no falling edge is seen until the line returns high.
- Assertions (simulation only):
  - BaudDiv ≥ 4;
  - FifoDepth is a power of two;
  - `byte_o` does not change while valid and not ready.

Optional Feature:
- Macro: VIP_UART_RX_PARITY_EN.
- Defined:
  - the PARITY state is inserted between DATA and STOP and samples one bit;
  - even parity is required, i.e. the XOR of the data bits and the parity bit equals 0;
  - on mismatch, `parity_err_o` pulses at the parity sample and the byte is discarded, but the STOP check still runs;
  - frame length is 11 bits.
- Undefined: no PARITY state, `parity_err_o` tied 0, frame length 10 bits.

Test Plan (BaudDiv=16):
1. Single byte 8'h41 at 16 cycles per bit, consumer ready → one `byte_valid_o` beat with 8'h41; `level_o` returns 0; no error pulses.
2. Glitch: line low for 5 cycles, then high → false start; no byte, no `frame_err_o`; the next byte 8'hA5 is decoded correctly.
3. Stop bit forced 0 on byte 8'h55 → `frame_err_o` pulses once; FIFO stays empty; line held low 100 cycles and then raised, followed by 8'h0A → 8'h0A received, `eol_cnt_o`=1.
4. Overflow with FifoDepth=8 and `byte_ready_i`=0: send 9 bytes 8'h00..8'h08 → `level_o`=8 and `overflow_o`=1. Then drain with ready=1 → bytes 8'h00..8'h07 in order; 8'h08 is lost.
5. Back-to-back push and pop at full: level 8, ready pulsed in the push cycle → `level_o` stays 8, `overflow_o` stays 0.
6. Assert `rst_i` during data bit 4 of 8'hFF, release, then send 8'h3C → only 8'h3C is received. With VIP_UART_RX_PARITY_EN: 8'h03 with parity bit 1 → `parity_err_o` pulses and no byte is pushed.

Source files
------------

// File: rtl/vip_uart_rx_monitor.sv
// UART receive monitor: 2-FF synchroniser, mid-bit sampling FSM and byte FIFO with valid/ready head.
// Define VIP_UART_RX_PARITY_EN to expect an even parity bit between the data bits and the stop bit.
module vip_uart_rx_monitor #(
  parameter int unsigned BaudDiv   = 16,
  parameter int unsigned FifoDepth = 8,
  parameter logic [7:0]  EolChar   = 8'h0A
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         uart_rx_i,
  output logic [7:0]                   byte_o,
  output logic                         byte_valid_o,
  input  logic                         byte_ready_i,
  output logic [$clog2(FifoDepth):0]   level_o,
  output logic                         frame_err_o,
  output logic                         parity_err_o,
  output logic                         overflow_o,
  output logic [15:0]                  eol_cnt_o
);

  localparam int unsigned CntW  = $clog2(BaudDiv);
  localparam int unsigned AddrW = $clog2(FifoDepth);
  localparam int unsigned LvlW  = AddrW + 1;
  localparam logic [CntW-1:0] HalfLoad = CntW'(BaudDiv / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(BaudDiv - 1);
  localparam logic [LvlW-1:0] FullLvl  = LvlW'(FifoDepth);

`ifdef VIP_UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_e;
`endif

  state_e            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              prev_q, prev_d;
  logic [1:0]        fill_q, fill_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              push_q, push_d;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       eol_q, eol_d;
  logic [7:0]        mem_q [FifoDepth];
  logic [7:0]        mem_d [FifoDepth];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   count_q, count_d;
  logic              expire, pop, full, accept;
`ifdef VIP_UART_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              parity_err_q, parity_err_d;
`endif

  assign expire = (cnt_q == '0);
  assign pop    = (count_q != '0) && byte_ready_i;
  assign full   = (count_q == FullLvl);
  assign accept = push_q && (!full || pop);

  always_comb begin
    state_d     = state_q;
    sync1_d     = uart_rx_i;
    sync2_d     = sync1_q;
    // prev only follows the line once the synchroniser holds real samples, so a
    // line that is low at reset release never looks like a falling edge.
    fill_d      = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    prev_d      = (fill_q == 2'd2) ? sync2_q : 1'b0;
    cnt_d       = expire ? cnt_q : cnt_q - CntW'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef VIP_UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = S_START;
          cnt_d   = HalfLoad;
        end
      end
      S_START: begin
        if (expire) begin
          if (sync2_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = FullLoad;
            idx_d   = 3'd0;
`ifdef VIP_UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end
      end
      S_DATA: begin
        if (expire) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = FullLoad;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef VIP_UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef VIP_UART_RX_PARITY_EN
      S_PARITY: begin
        if (expire) begin
          cnt_d        = FullLoad;
          par_bad_d    = (^shift_q) ^ sync2_q;
          parity_err_d = (^shift_q) ^ sync2_q;
          state_d      = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (expire) begin
          if (sync2_q) begin
`ifdef VIP_UART_RX_PARITY_EN
            push_d = !par_bad_q;
`else
            push_d = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte FIFO; shift_q still holds the completed byte during the push cycle.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    eol_d      = eol_q;
    if (accept) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + AddrW'(1);
      if (shift_q == EolChar) eol_d = eol_q + 16'd1;
    end else if (push_q) begin
      overflow_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AddrW'(1);
    unique case ({accept, pop})
      2'b10:   count_d = count_q + LvlW'(1);
      2'b01:   count_d = count_q - LvlW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b0;
      fill_q      <= 2'd0;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      eol_q       <= 16'd0;
      mem_q       <= '{default: 8'h00};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef VIP_UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      eol_q       <= eol_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef VIP_UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign byte_o       = mem_q[rd_ptr_q];
  assign byte_valid_o = (count_q != '0);
  assign level_o      = count_q;
  assign frame_err_o  = frame_err_q;
  assign overflow_o   = overflow_q;
  assign eol_cnt_o    = eol_q;
`ifdef VIP_UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (BaudDiv >= 4) else $error("BaudDiv must be at least 4");
      assert ((FifoDepth & (FifoDepth - 1)) == 0) else $error("FifoDepth must be a power of two");
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
                   (byte_valid_o && !byte_ready_i) |=> $stable(byte_o))
    else $error("byte_o changed while stalled");
`endif

endmodule
